scan_rx_ctrl: RTL and testbench
===============================

Name: scan_rx_ctrl

Overview:
- Processor-side end of the dual-scanner transfer interface; the counterpart of the scanner pair's readyToTransfer / transfer / data_out handshake.
- Issues the startScanning pulse and watches readyToTransfer.
- Grants a transfer only when a full block fits locally, then captures the streamed block into an internal FIFO.
- Downstream logic (hex display, host) pops bytes from the FIFO.

Parameters:
- BLOCK_LEN, 8, bytes streamed per transfer (scanner buffer size); range 1..15.
- XFER_LAT, 1, cycles from the transfer pulse to the first valid byte on data_in; range 1..3.
- FIFO_DEPTH, 16, local FIFO entries; power of 2, must be >= BLOCK_LEN.

Ports:
- clk  in  1  system clock (same divided clock as the scanners).
- rst  in  1  asynchronous, active-low reset.
- start_req  in  1  request a scan session; level, sampled in IDLE.
- readyToTransfer  in  1  high while either scanner holds a full buffer.
- data_in  in  8  scanner data_out bus.
- rd_en  in  1  pop one FIFO byte; ignored when empty.
- startScanning  out  1  one-cycle pulse to begin scanning.
- transfer  out  1  one-cycle grant pulse to the ready scanner.
- rd_data  out  8  FIFO head byte; valid when empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  5  FIFO occupancy, 0..FIFO_DEPTH.
- blocks_rx  out  8  completed-block counter; wraps 255->0.
- busy  out  1  high in every state except IDLE.

Behaviour:
Reset (rst=0, asynchronous):
- FSM to IDLE.
- startScanning=0, transfer=0, rd_data=0, empty=1, full=0, level=0, blocks_rx=0, busy=0.
- FIFO pointers cleared; FIFO contents are don't-care.
- Reset mid-capture discards the partial block, and no transfer or startScanning pulse follows reset release.

FSM states and transitions:
- IDLE: if start_req=1, go to START.
- START: assert startScanning for exactly one cycle, then go to WAIT_RDY.
- WAIT_RDY: if readyToTransfer=1 and free space (FIFO_DEPTH-level) >= BLOCK_LEN, go to GRANT. Otherwise hold; no grant is ever issued without room.
- GRANT: assert transfer for exactly one cycle, then go to LAT with lat_cnt=XFER_LAT-1.
- LAT: count down. Leave for CAP in the cycle in which data_in holds byte 0, i.e. byte 0 is sampled XFER_LAT cycles after the GRANT cycle.
- CAP: push data_in every cycle for BLOCK_LEN consecutive cycles (byte index 0..BLOCK_LEN-1). After the last push, increment blocks_rx and go to WAIT_RDY. Scanners alternate, so the next ready block is served with no further startScanning.
- Return from WAIT_RDY to IDLE only when start_req=0 and readyToTransfer=0.

Capture rules:
- readyToTransfer is ignored during GRANT, LAT and CAP.
- A readyToTransfer drop mid-CAP does not abort; all BLOCK_LEN bytes are captured.

FIFO:
- Synchronous write and read.
- rd_data shows the head combinationally from the registered read pointer; a pop advances it next cycle.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pop when empty is ignored.
- A push when full cannot occur, because the grant rule guarantees room. The FIFO must still never overwrite: a push while full is dropped (verification assertion).
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; level is tracked separately.
- full = (level==FIFO_DEPTH); empty = (level==0).

Latency:
- transfer rises 1 cycle after the WAIT_RDY condition is met.
- First byte is visible on rd_data 1 cycle after its push.

Optional Feature:
- Macro: SCAN_RX_CHECKSUM_EN.
- Defined: adds output blk_sum [7:0], the mod-256 sum of the bytes of the last completed block.
  - Updated in the cycle blocks_rx increments; reset value 0.
  - The running accumulator clears on GRANT.
  - A partial block aborted by reset does not update blk_sum.
- Undefined: no blk_sum port, no accumulator logic; all other behaviour identical.

Test Plan:
- Basic block: reset, start_req=1; readyToTransfer=1 two cycles after the startScanning pulse; drive bytes 0x10..0x17 from the cycle XFER_LAT after transfer. Required: exactly one transfer pulse, level=8, blocks_rx=1, and pops return 0x10..0x17 in order.
- Back-pressure: pre-fill 9 bytes (no pops), assert readyToTransfer. Required: transfer stays 0 until level<=8; pop 1 byte and transfer pulses the cycle after free space reaches 8.
- Alternating scanners: three consecutive ready blocks (0xA0.., 0xB0.., 0xC0..) with rd_en=1 continuously. Required: blocks_rx=3, 24 bytes popped in order, level never exceeds 8, a single startScanning pulse.
- Simultaneous push/pop at FIFO_DEPTH-1 and pointer wrap over 40 bytes. Required: no loss or duplication; full asserted exactly when level=16.
- Reset mid-CAP after byte 3. Required: all outputs at reset values immediately; after release no transfer until the next readyToTransfer with start_req.
- SCAN_RX_CHECKSUM_EN defined, block 0xFF,0x01,0x02,0,0,0,0,0. Required: blk_sum=0x02.

Source files
------------

// File: rtl/scan_rx_ctrl.sv
// scan_rx_ctrl: processor-side receiver for the dual-scanner transfer handshake, with local byte FIFO.
// Optional `SCAN_RX_CHECKSUM_EN adds blk_sum, the mod-256 sum of the last completed block.
module scan_rx_ctrl #(
    parameter int unsigned BLOCK_LEN  = 8,
    parameter int unsigned XFER_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       readyToTransfer,
    input  logic [7:0] data_in,
    input  logic       rd_en,
    output logic       startScanning,
    output logic       transfer,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic [4:0] level,
    output logic [7:0] blocks_rx,
`ifdef SCAN_RX_CHECKSUM_EN
    output logic [7:0] blk_sum,
`endif
    output logic       busy
);

    localparam int unsigned AW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  GRANT_MAX_LVL = 5'(FIFO_DEPTH - BLOCK_LEN);
    localparam logic [4:0]  FULL_LVL      = 5'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_IDX      = 4'(BLOCK_LEN - 1);
    localparam logic [1:0]  LAT_INIT      = 2'(XFER_LAT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_RDY, GRANT, LAT, CAP} state_t;

    state_t        state_q;
    logic [1:0]    lat_cnt_q;
    logic [3:0]    idx_q;
    logic          start_q, xfer_q, busy_q;
    logic [7:0]    blocks_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          cap_fire, push, pop, full_w, empty_w;

    // Byte 0 arrives in the last LAT cycle, so capture starts there rather than in CAP.
    assign cap_fire = (state_q == CAP) || ((state_q == LAT) && (lat_cnt_q == '0));
    assign full_w   = (level_q == FULL_LVL);
    assign empty_w  = (level_q == '0);
    assign push     = cap_fire && !full_w;
    assign pop      = rd_en && !empty_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            idx_q     <= '0;
            start_q   <= 1'b0;
            xfer_q    <= 1'b0;
            busy_q    <= 1'b0;
            blocks_q  <= '0;
        end else begin
            start_q <= 1'b0;
            xfer_q  <= 1'b0;
            case (state_q)
                IDLE: if (start_req) begin
                    state_q <= START;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                START: state_q <= WAIT_RDY;
                WAIT_RDY: begin
                    if (readyToTransfer && (level_q <= GRANT_MAX_LVL)) begin
                        state_q <= GRANT;
                        xfer_q  <= 1'b1;
                    end else if (!start_req && !readyToTransfer) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    state_q   <= LAT;
                    lat_cnt_q <= LAT_INIT;
                    idx_q     <= '0;
                end
                LAT, CAP: begin
                    if (cap_fire) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= WAIT_RDY;
                            blocks_q <= blocks_q + 8'd1;
                        end else begin
                            state_q <= CAP;
                            idx_q   <= idx_q + 4'd1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SCAN_RX_CHECKSUM_EN
    logic [7:0] sum_q, blk_sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q     <= '0;
            blk_sum_q <= '0;
        end else if (state_q == GRANT) begin
            sum_q <= '0;
        end else if (cap_fire) begin
            sum_q <= sum_q + data_in;
            if (idx_q == LAST_IDX) blk_sum_q <= sum_q + data_in;
        end
    end

    assign blk_sum = blk_sum_q;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(cap_fire && full_w));

    assign rd_data       = empty_w ? '0 : mem_q[rd_ptr_q];
    assign empty         = empty_w;
    assign full          = full_w;
    assign level         = level_q;
    assign blocks_rx     = blocks_q;
    assign startScanning = start_q;
    assign transfer      = xfer_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_scan_rx_ctrl.sv
// Randomized bench for scan_rx_ctrl against a queue-based protocol model.
// Build with +define+SCAN_RX_CHECKSUM_EN to also check blk_sum.
module tb_scan_rx_ctrl;

    localparam int unsigned BL    = 8;
    localparam int unsigned XL    = 1;
    localparam int unsigned DEPTH = 16;

    logic       clk, rst, start_req, readyToTransfer, rd_en;
    logic [7:0] data_in;
    logic       startScanning, transfer, empty, full, busy;
    logic [7:0] rd_data, blocks_rx;
    logic [4:0] level;
`ifdef SCAN_RX_CHECKSUM_EN
    logic [7:0] blk_sum;
`endif

    scan_rx_ctrl #(.BLOCK_LEN(BL), .XFER_LAT(XL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_req(start_req), .readyToTransfer(readyToTransfer),
        .data_in(data_in), .rd_en(rd_en), .startScanning(startScanning), .transfer(transfer),
        .rd_data(rd_data), .empty(empty), .full(full), .level(level), .blocks_rx(blocks_rx),
`ifdef SCAN_RX_CHECKSUM_EN
        .blk_sum(blk_sum),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0, bad = 0;

    // Model: phase 0 idle, 1 start pulse, 2 waiting for ready, 3 transfer (cnt = cycles since grant).
    int          ph = 0, cnt = 0, rdy_blocks = 0;
    logic [7:0]  mq[$], send_q[$], pops[$];
    logic [7:0]  blocks_exp = '0, sum_acc = '0, blk_exp = '0;
    bit          rnd_pop = 1'b0;
    int unsigned dut_xfer = 0, dut_ss = 0, dut_max = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ss"}, startScanning, 0);
        chk({tag, "_xfer"}, transfer, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_blocks"}, blocks_rx, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef SCAN_RX_CHECKSUM_EN
        chk({tag, "_blk_sum"}, blk_sum, 0);
`endif
    endtask

    task automatic tick();
        int n, nph, ncnt;
        bit do_pop, do_push, blk_end;
        logic [7:0] pb;
        n = mq.size();
        if (rnd_pop) rd_en = ($urandom_range(0, 3) == 0);
        do_pop  = rd_en && (n != 0);
        do_push = 1'b0;
        blk_end = 1'b0;
        pb      = '0;
        nph     = ph;
        ncnt    = cnt;
        case (ph)
            0: if (start_req) nph = 1;
            1: nph = 2;
            2: begin
                if (readyToTransfer && (int'(DEPTH) - n >= int'(BL))) begin
                    nph = 3;
                    ncnt = 0;
                end else if (!start_req && !readyToTransfer) begin
                    nph = 0;
                end
            end
            default: begin
                if (cnt >= int'(XL)) begin
                    do_push = 1'b1;
                    pb = data_in;
                end
                if (cnt == int'(XL + BL) - 1) begin
                    nph = 2;
                    blk_end = 1'b1;
                end else begin
                    ncnt = cnt + 1;
                end
            end
        endcase
        if (rd_en && !empty) pops.push_back(rd_data);

        @(posedge clk);
        #1;

        if (do_pop) void'(mq.pop_front());
        if (nph == 3 && ncnt == 0) begin
            sum_acc = '0;
            rdy_blocks--;
        end
        if (do_push) begin
            mq.push_back(pb);
            sum_acc = sum_acc + pb;
        end
        if (blk_end) begin
            blocks_exp = blocks_exp + 8'd1;
            blk_exp = sum_acc;
        end
        ph  = nph;
        cnt = ncnt;

        if (transfer) dut_xfer++;
        if (startScanning) dut_ss++;
        if (int'(level) > int'(dut_max)) dut_max = level;

        chk("startScanning", startScanning, ph == 1);
        chk("transfer", transfer, (ph == 3) && (cnt == 0));
        chk("busy", busy, ph != 0);
        chk("level", level, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("blocks_rx", blocks_rx, blocks_exp);
        if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
`ifdef SCAN_RX_CHECKSUM_EN
        chk("blk_sum", blk_sum, blk_exp);
`endif

        if (ph == 3) readyToTransfer = ($urandom_range(0, 1) == 1);
        else readyToTransfer = (rdy_blocks > 0);
        if (ph == 3 && cnt >= int'(XL) && send_q.size() != 0) data_in = send_q.pop_front();
        else data_in = 8'($urandom);
    endtask

    task automatic set_rdy(input int nblk);
        rdy_blocks = nblk;
        if (ph != 3) readyToTransfer = (nblk > 0);
    endtask

    task automatic run_blocks(input string tag, input logic [7:0] target, input int unsigned budget);
        for (int unsigned i = 0; i < budget && blocks_exp != target; i++) tick();
        chk(tag, blocks_rx, target);
    endtask

    task automatic drain(input int unsigned n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        ph = 0;
        cnt = 0;
        mq.delete();
        send_q.delete();
        blocks_exp = '0;
        sum_acc = '0;
        blk_exp = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        int unsigned x0, s0;
        rst = 1'b0; start_req = 1'b0; readyToTransfer = 1'b0; data_in = '0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b1;

        // Basic block
        start_req = 1'b1;
        tick();
        tick();
        tick();
        for (int unsigned i = 0; i < BL; i++) send_q.push_back(8'(8'h10 + i));
        x0 = dut_xfer;
        set_rdy(1);
        run_blocks("t1_blocks", 8'd1, 40);
        start_req = 1'b0;
        chk("t1_xfers", dut_xfer - x0, 1);
        chk("t1_level", level, 8);
        pops.delete();
        drain(BL);
        chk("t1_npops", pops.size(), BL);
        for (int unsigned i = 0; i < pops.size(); i++) chk("t1_pop", pops[i], 8'h10 + i);
        tick();

        // Back-pressure: fill to 16, pop down to 9, grant only once free space reaches 8
        start_req = 1'b1;
        set_rdy(2);
        run_blocks("t2_fill", 8'd3, 80);
        chk("t2_full", full, 1);
        drain(7);
        set_rdy(1);
        x0 = dut_xfer;
        repeat (6) tick();
        chk("t2_level9", level, 9);
        chk("t2_no_xfer", dut_xfer - x0, 0);
        drain(1);
        chk("t2_still_0", transfer, 0);
        tick();
        chk("t2_xfer", dut_xfer - x0, 1);
        run_blocks("t2_blocks", 8'd4, 40);
        drain(DEPTH);
        start_req = 1'b0;
        repeat (2) tick();

        // Alternating scanners with continuous pops
        pops.delete();
        s0 = dut_ss;
        dut_max = 0;
        for (int unsigned b = 0; b < 3; b++)
            for (int unsigned i = 0; i < BL; i++) send_q.push_back(8'(8'hA0 + 16 * b + i));
        rd_en = 1'b1;
        start_req = 1'b1;
        set_rdy(3);
        run_blocks("t3_blocks", 8'd7, 120);
        for (int unsigned i = 0; i < 20 && mq.size() != 0; i++) tick();
        rd_en = 1'b0;
        chk("t3_npops", pops.size(), 3 * BL);
        for (int unsigned i = 0; i < pops.size(); i++) begin
            e = 8'(8'hA0 + 16 * (i / BL) + (i % BL));
            chk("t3_pop", pops[i], e);
        end
        chk("t3_maxlvl_le8", dut_max <= 8, 1);
        chk("t3_ss_pulses", dut_ss - s0, 1);

        // Random pops over 40 bytes: pointer wrap, simultaneous push/pop near full
        rnd_pop = 1'b1;
        set_rdy(5);
        run_blocks("t4_blocks", 8'd12, 400);
        rnd_pop = 1'b0;
        rd_en = 1'b1;
        for (int unsigned i = 0; i < 40 && mq.size() != 0; i++) tick();
        rd_en = 1'b0;
        chk("t4_empty", empty, 1);

        // Reset after byte 3 of a capture
        set_rdy(1);
        for (int unsigned i = 0; i < 60 && !(ph == 3 && cnt == int'(XL) + 4); i++) tick();
        chk("t5_partial", level, 4);
        #2 rst = 1'b0;
        #1 reset_checks("t5_async");
        model_reset();
        start_req = 1'b0;
        rdy_blocks = 1;
        readyToTransfer = 1'b1;
        @(posedge clk);
        #1 reset_checks("t5_hold");
        rst = 1'b1;
        x0 = dut_xfer;
        s0 = dut_ss;
        repeat (5) tick();
        chk("t5_no_xfer", dut_xfer - x0, 0);
        chk("t5_no_ss", dut_ss - s0, 0);
        start_req = 1'b1;
        run_blocks("t5_blocks", 8'd1, 40);
        drain(BL);

        // Checksum block
        send_q = '{8'hFF, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_rdy(1);
        run_blocks("t6_blocks", 8'd2, 40);
`ifdef SCAN_RX_CHECKSUM_EN
        chk("t6_blk_sum", blk_sum, 8'h02);
`endif
        pops.delete();
        drain(BL);
        chk("t6_pop0", pops[0], 8'hFF);
        chk("t6_pop2", pops[2], 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
